// File: rtl/cs_arb.sv
// Two-requester round-robin front end for a shared checksum engine.
// One job in flight: capture, launch, wait for the result or a timeout, then respond to the owner.
module cs_arb #(
   parameter int WIDTH_DATA   = 128,
   parameter int WIDTH_RESULT = 8,
   parameter int TIMEOUT      = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              req_valid,
   input  logic [WIDTH_DATA-1:0]   req_data0,
   input  logic [WIDTH_DATA-1:0]   req_data1,
   output logic [1:0]              gnt,
   output logic [1:0]              resp_valid,
   output logic [WIDTH_RESULT-1:0] resp_result,
   output logic                    resp_err,
   output logic                    busy,
   output logic                    eng_in_valid,
   output logic [WIDTH_DATA-1:0]   eng_data,
   input  logic                    eng_out_valid,
   input  logic [WIDTH_RESULT-1:0] eng_result
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] cnt;
   logic       owner;
   logic       last;
   logic       pick;

   // On a tie the requester that did not win last time goes first.
   always_comb begin
      pick = 1'b0;
      case (req_valid)
         2'b10:   pick = 1'b1;
         2'b11:   pick = ~last;
         default: pick = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= 8'd0;
         owner        <= 1'b0;
         last         <= 1'b1;
         gnt          <= 2'b00;
         resp_valid   <= 2'b00;
         resp_result  <= '0;
         resp_err     <= 1'b0;
         busy         <= 1'b0;
         eng_in_valid <= 1'b0;
         eng_data     <= '0;
      end else begin
         gnt          <= 2'b00;
         resp_valid   <= 2'b00;
         resp_result  <= '0;
         resp_err     <= 1'b0;
         eng_in_valid <= 1'b0;
         eng_data     <= '0;
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  owner        <= pick;
                  last         <= pick;
                  gnt          <= pick ? 2'b10 : 2'b01;
                  eng_in_valid <= 1'b1;
                  eng_data     <= pick ? req_data1 : req_data0;
                  cnt          <= 8'd0;
                  busy         <= 1'b1;
                  state        <= WAIT;
               end
            end
            WAIT: begin
               // A result arriving on the timeout edge still counts as a good result.
               if (eng_out_valid) begin
                  resp_valid  <= owner ? 2'b10 : 2'b01;
                  resp_result <= eng_result;
                  state       <= RESP;
               end else if (cnt == CNT_LAST) begin
                  resp_valid <= owner ? 2'b10 : 2'b01;
                  resp_err   <= 1'b1;
                  state      <= RESP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RESP: begin
               cnt   <= 8'd0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cs_arb.sv
// Directed bench for cs_arb with a small fixed-latency engine model (result = data[7:0] ^ 8'h5A).
module tb_cs_arb;

   localparam int DW = 32;
   localparam int RW = 8;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    req_valid = 2'b00;
   logic [DW-1:0] req_data0 = '0;
   logic [DW-1:0] req_data1 = '0;
   logic [1:0]    gnt;
   logic [1:0]    resp_valid;
   logic [RW-1:0] resp_result;
   logic          resp_err;
   logic          busy;
   logic          eng_in_valid;
   logic [DW-1:0] eng_data;
   logic          eng_out_valid = 1'b0;
   logic [RW-1:0] eng_result = '0;

   int            checks = 0;
   int            failures = 0;
   int            eng_lat = 3;
   int            eng_cnt = 0;
   logic [RW-1:0] eng_res = '0;

   cs_arb #(.WIDTH_DATA(DW), .WIDTH_RESULT(RW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
      .req_data0(req_data0), .req_data1(req_data1),
      .gnt(gnt), .resp_valid(resp_valid), .resp_result(resp_result),
      .resp_err(resp_err), .busy(busy), .eng_in_valid(eng_in_valid),
      .eng_data(eng_data), .eng_out_valid(eng_out_valid), .eng_result(eng_result)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge and run the engine model there.
   task automatic tick();
      @(negedge clk);
      if (eng_out_valid) begin
         eng_out_valid = 1'b0;
         eng_result    = '0;
      end
      if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0) begin
            eng_out_valid = 1'b1;
            eng_result    = eng_res;
         end
      end
      if (eng_in_valid && eng_lat > 0) begin
         eng_cnt = eng_lat;
         eng_res = eng_data[7:0] ^ 8'h5A;
      end
   endtask

   task automatic check_quiet(input string tag);
      check_val(tag, {gnt, resp_valid, resp_result, resp_err, busy, eng_in_valid, eng_data}, 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      bit   order[$];
      int   low_run;
      bit   started;
      int   resp_cnt;

      // Reset state
      tick();
      tick();
      check_quiet("reset_outs");
      rst_n = 1'b1;
      tick();
      check_quiet("idle_outs");

      // Single job, engine latency 3
      eng_lat   = 3;
      req_data0 = 32'hDEAD_BEEF;
      req_valid = 2'b01;
      tick();
      check_val("t1_gnt", gnt, 2'b01);
      check_val("t1_launch", eng_in_valid, 1'b1);
      check_val("t1_data", eng_data, 32'hDEAD_BEEF);
      check_val("t1_busy", busy, 1'b1);
      req_valid = 2'b00;
      tick();
      check_val("t1_gnt_once", gnt, 2'b00);
      tick();
      tick();
      check_val("t1_early_resp", resp_valid, 2'b00);
      tick();
      check_val("t1_resp", resp_valid, 2'b01);
      check_val("t1_result", resp_result, 8'hB5);
      check_val("t1_err", resp_err, 1'b0);
      tick();
      check_quiet("t1_after");

      // Tie held after reset: 0,1,0,1 with a one-cycle idle gap
      do_reset();
      eng_lat   = 3;
      req_data0 = 32'h0000_00A0;
      req_data1 = 32'h0000_00B1;
      req_valid = 2'b11;
      low_run   = 0;
      started   = 1'b0;
      resp_cnt  = 0;
      for (int i = 0; i < 26; i++) begin
         tick();
         check_val("tie_gnt_onehot", $onehot0(gnt), 1'b1);
         if (resp_valid != 2'b00) begin
            check_val("tie_resp_owner", resp_valid, (resp_cnt % 2) ? 2'b10 : 2'b01);
            check_val("tie_resp_result", resp_result, (resp_cnt % 2) ? 8'hEB : 8'hFA);
            resp_cnt++;
         end
         if (gnt != 2'b00) begin
            check_val("tie_data", eng_data, gnt[1] ? 32'h0000_00B1 : 32'h0000_00A0);
            order.push_back(gnt[1]);
            if (order.size() == 4) req_valid = 2'b00;
         end
         if (!busy) low_run++;
         else begin
            if (started && low_run > 0) check_val("tie_busy_gap", low_run, 1);
            low_run = 0;
            started = 1'b1;
         end
      end
      check_val("tie_grants", order.size(), 4);
      check_val("tie_resps", resp_cnt, 4);
      for (int i = 0; i < order.size(); i++)
         check_val("tie_order", order[i], i % 2);

      // Timeout with a silent engine, then late strobes
      eng_lat   = 0;
      req_data0 = 32'h0000_0C0C;
      req_valid = 2'b01;
      tick();
      check_val("to_gnt", gnt, 2'b01);
      req_valid = 2'b00;
      repeat (7) tick();
      check_val("to_early", resp_valid, 2'b00);
      check_val("to_busy", busy, 1'b1);
      tick();
      check_val("to_resp", resp_valid, 2'b01);
      check_val("to_err", resp_err, 1'b1);
      check_val("to_result", resp_result, 8'h00);
      eng_out_valid = 1'b1;
      eng_result    = 8'h77;
      tick();
      check_quiet("to_late_resp_state");
      eng_out_valid = 1'b1;
      eng_result    = 8'h77;
      tick();
      check_quiet("to_late_idle");
      tick();
      check_quiet("to_late_idle2");

      // Result on the last WAIT cycle wins over the timeout
      eng_lat   = 7;
      req_data0 = 32'h1234_5678;
      req_valid = 2'b01;
      tick();
      check_val("bd_gnt", gnt, 2'b01);
      req_valid = 2'b00;
      repeat (7) tick();
      check_val("bd_early", resp_valid, 2'b00);
      tick();
      check_val("bd_resp", resp_valid, 2'b01);
      check_val("bd_err", resp_err, 1'b0);
      check_val("bd_result", resp_result, 8'h22);
      tick();

      // Reset in WAIT drops the job; last winner returns to 1
      eng_lat   = 0;
      req_data0 = 32'h0000_0055;
      req_data1 = 32'h0000_0066;
      req_valid = 2'b01;
      tick();
      check_val("rw_gnt", gnt, 2'b01);
      req_valid = 2'b00;
      tick();
      rst_n = 1'b0;
      tick();
      check_quiet("rw_reset_outs");
      rst_n         = 1'b1;
      eng_out_valid = 1'b1;
      eng_result    = 8'h99;
      tick();
      check_quiet("rw_late_result");
      resp_cnt = 0;
      repeat (10) begin
         tick();
         if (resp_valid != 2'b00) resp_cnt++;
      end
      check_val("rw_no_resp", resp_cnt, 0);
      req_valid = 2'b11;
      tick();
      check_val("rw_tie_gnt", gnt, 2'b01);
      req_valid = 2'b00;
      repeat (12) tick();

      // Stray engine strobe in IDLE
      check_quiet("stray_before");
      eng_out_valid = 1'b1;
      eng_result    = 8'hAB;
      tick();
      check_quiet("stray_1");
      tick();
      check_quiet("stray_2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
